// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/multiply sequencer for the 5-stage MIPS core (optional HAZARD_PERF_CNT_EN)
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       IDEX_memread_i,
  input  logic [4:0] IDEX_rt_i,
  input  logic [4:0] IFID_rs_i,
  input  logic [4:0] IFID_rt_i,
  input  logic       IFID_mul_i,
  input  logic       branch_taken_i,
  output logic       pc_write_o,
  output logic       IFID_write_o,
  output logic       IDEX_bubble_o,
  output logic       IFID_flush_o,
  output logic       mul_start_o,
  output logic       mul_valid_o,
  output logic       busy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  // Wait counter only has to hold MUL_LAT-1, so it never wraps.
  localparam int CW = $clog2(MUL_LAT);

  // Illegal parameter values stop elaboration.
  if (MUL_LAT < 2 || MUL_LAT > 15 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl: MUL_LAT must be 2..15 and CNT_W at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MUL_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu;

  // Load in EX feeding ID: forwarding cannot cover it, so ID must wait one cycle.
  assign lu = IDEX_memread_i && (IDEX_rt_i != 5'd0) &&
              ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));

  // State and multiply wait counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline controls; the default is a stall with everything else quiet.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_o    = 1'b0;
    IFID_write_o  = 1'b0;
    IDEX_bubble_o = 1'b1;
    IFID_flush_o  = 1'b0;
    mul_start_o   = 1'b0;
    mul_valid_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (lu) begin
          // Stall only; branch/multiply in ID are re-seen next cycle.
          state_d = ST_RUN;
        end else if (IFID_mul_i) begin
          mul_start_o = 1'b1;
          cnt_d       = CW'(MUL_LAT - 1);
          state_d     = ST_MUL_WAIT;
        end else begin
          pc_write_o    = 1'b1;
          IFID_write_o  = 1'b1;
          IDEX_bubble_o = 1'b0;
          IFID_flush_o  = branch_taken_i;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Release: the multiply leaves ID now, so RUN will not see it again.
          pc_write_o    = 1'b1;
          IFID_write_o  = 1'b1;
          IDEX_bubble_o = 1'b0;
          mul_valid_o   = 1'b1;
          state_d       = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q != ST_RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = !pc_write_o && (state_q != ST_IDLE);
  assign flush_inc = IFID_flush_o;

  // Saturating stall and flush event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  logic       clk;
  logic       rst_i, start_i, IDEX_memread_i, IFID_mul_i, branch_taken_i;
  logic [4:0] IDEX_rt_i, IFID_rs_i, IFID_rt_i;
  logic       pc_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o;
  logic       mul_start_o, mul_valid_o, busy_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .IDEX_memread_i (IDEX_memread_i),
    .IDEX_rt_i      (IDEX_rt_i),
    .IFID_rs_i      (IFID_rs_i),
    .IFID_rt_i      (IFID_rt_i),
    .IFID_mul_i     (IFID_mul_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc_write_o),
    .IFID_write_o   (IFID_write_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .IFID_flush_o   (IFID_flush_o),
    .mul_start_o    (mul_start_o),
    .mul_valid_o    (mul_valid_o),
    .busy_o         (busy_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output pack order: {pc_write, IFID_write, bubble, flush, mul_start, mul_valid, busy}
  localparam logic [6:0] O_IDLE  = 7'b0010001;
  localparam logic [6:0] O_FREE  = 7'b1100000;
  localparam logic [6:0] O_STALL = 7'b0010000;
  localparam logic [6:0] O_MS    = 7'b0010100;
  localparam logic [6:0] O_WAIT  = 7'b0010001;
  localparam logic [6:0] O_REL   = 7'b1100011;
  localparam logic [6:0] O_FLUSH = 7'b1101000;

  typedef struct {
    logic       rst;
    logic       start;
    logic       memread;
    logic [4:0] rt_ex;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mul;
    logic       br;
    logic       in_idle;
    logic [6:0] exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic mv_seen;

  function automatic vec_t mk(input logic rst, input logic start, input logic memread,
                              input logic [4:0] rt_ex, input logic [4:0] rs, input logic [4:0] rt,
                              input logic mul, input logic br, input logic in_idle,
                              input logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.start = start; v.memread = memread; v.rt_ex = rt_ex;
    v.rs = rs; v.rt = rt; v.mul = mul; v.br = br; v.in_idle = in_idle; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {pc_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o,
            mul_start_o, mul_valid_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_i          = v.rst;
    start_i        = v.start;
    IDEX_memread_i = v.memread;
    IDEX_rt_i      = v.rt_ex;
    IFID_rs_i      = v.rs;
    IFID_rt_i      = v.rt;
    IFID_mul_i     = v.mul;
    branch_taken_i = v.br;
  endtask

  initial begin
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_FREE);

    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    vecs[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, O_IDLE);   // start sampled, still idle outputs
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_FREE);
    vecs[5]  = mk(0, 0, 1, 5, 5, 0, 0, 0, 0, O_STALL);  // load-use on rs
    vecs[6]  = mk(0, 0, 0, 5, 5, 0, 0, 0, 0, O_FREE);
    vecs[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, O_FREE);   // $zero never hazards
    vecs[8]  = mk(0, 0, 1, 7, 3, 7, 0, 0, 0, O_STALL);  // load-use on rt
    vecs[9]  = mk(0, 0, 1, 7, 3, 4, 0, 0, 0, O_FREE);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH);
    vecs[11] = mk(0, 0, 1, 9, 9, 0, 1, 1, 0, O_STALL);  // lu beats mul and branch
    vecs[12] = mk(0, 0, 0, 9, 9, 0, 1, 0, 0, O_MS);
    vecs[13] = mk(0, 0, 1, 9, 9, 0, 1, 1, 0, O_WAIT);   // all requests ignored while waiting
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_WAIT);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_WAIT);
    vecs[16] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, O_REL);    // release, no retrigger/flush
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_MS);     // back-to-back multiply
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_WAIT);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_WAIT);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_WAIT);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_REL);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_FREE);   // start low does not return to IDLE
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH);

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE));

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), {25'd0, outs()}, {25'd0, vecs[i].exp});
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("vec%0d_stall_cnt", i), stall_cnt_o, exp_stall);
      chk($sformatf("vec%0d_flush_cnt", i), flush_cnt_o, exp_flush);
`endif
      if (!vecs[i].rst && !vecs[i].in_idle && !vecs[i].exp[6]) exp_stall++;
      if (!vecs[i].rst && vecs[i].exp[3]) exp_flush++;
    end

    // Reset asserted in the middle of a multiply wait (cnt = 2).
    @(negedge clk); drive(z); IFID_mul_i = 1'b1;
    #1 chk("mid_issue", {25'd0, outs()}, {25'd0, O_MS});
    @(negedge clk); drive(z);
    #1 chk("mid_wait_cnt3", {25'd0, outs()}, {25'd0, O_WAIT});
    @(negedge clk);
    #1 chk("mid_wait_cnt2", {25'd0, outs()}, {25'd0, O_WAIT});
    rst_i = 1'b1;
    #1 chk("mid_async_reset", {25'd0, outs()}, {25'd0, O_IDLE});
`ifdef HAZARD_PERF_CNT_EN
    chk("mid_reset_stall_cnt", stall_cnt_o, 0);
    chk("mid_reset_flush_cnt", flush_cnt_o, 0);
`endif
    mv_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1 mv_seen = mv_seen | mul_valid_o;
    end
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1 mv_seen = mv_seen | mul_valid_o;
    end
    chk("no_mul_valid_after_reset", {31'd0, mv_seen}, 32'd0);
    chk("idle_after_reset", {25'd0, outs()}, {25'd0, O_IDLE});

    // Restart from IDLE.
    @(negedge clk); start_i = 1'b1;
    #1 chk("restart_idle_cycle", {25'd0, outs()}, {25'd0, O_IDLE});
    @(negedge clk); start_i = 1'b0;
    #1 chk("restart_run", {25'd0, outs()}, {25'd0, O_FREE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It owns the PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Detects load-use hazards that EX/MEM/WB forwarding cannot cover and applies branch-taken flushes.
- Schedules a multi-cycle multiplier issued from ID by holding the front end for a fixed latency.
- Gates pipeline start-up after reset.

Parameters:
- MUL_LAT, 4, multiplier latency in cycles; legal range 2..15.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  CPU start; pipeline stays idle until it is sampled high
- IDEX_memread_i  in  1  instruction in EX is a load
- IDEX_rt_i  in  5  load destination register in EX
- IFID_rs_i  in  5  rs of instruction in ID
- IFID_rt_i  in  5  rt of instruction in ID
- IFID_mul_i  in  1  instruction in ID is a multi-cycle multiply
- branch_taken_i  in  1  branch in ID resolved taken
- pc_write_o  out  1  PC update enable
- IFID_write_o  out  1  IF/ID register write enable
- IDEX_bubble_o  out  1  zero the control bits entering ID/EX
- IFID_flush_o  out  1  clear IF/ID (squash fetched instruction)
- mul_start_o  out  1  one-cycle pulse: start the multiplier
- mul_valid_o  out  1  multiplier result valid; the multiply leaves ID this cycle
- busy_o  out  1  state is not RUN

Behaviour:
- States: IDLE, RUN, MUL_WAIT. Reset enters IDLE and clears the counter.
  - Reset output values: pc_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, all other outputs 0, busy_o=1.
- All outputs are combinational from the state and the inputs.
- Definition: stall means pc_write_o=0, IFID_write_o=0, IDEX_bubble_o=1. Free-run means pc_write_o=1, IFID_write_o=1, IDEX_bubble_o=0.
- Load-use hazard: lu = IDEX_memread_i && IDEX_rt_i!=0 && (IDEX_rt_i==IFID_rs_i || IDEX_rt_i==IFID_rt_i).
- IDLE:
  - Outputs are at their reset values.
  - Moves to RUN on the next edge when start_i=1.
- RUN, priority high to low:
  1. lu: stall for 1 cycle, stay in RUN. Branch and multiply requests in ID are deferred, because the instruction is re-presented next cycle.
  2. IFID_mul_i: stall, mul_start_o=1, load cnt=MUL_LAT-1, go to MUL_WAIT.
  3. branch_taken_i: free-run with IFID_flush_o=1, stay in RUN.
  4. Otherwise free-run.
- MUL_WAIT:
  - While cnt!=0: stall, decrement cnt.
  - When cnt==0: free-run, mul_valid_o=1, go to RUN.
  - lu, branch_taken_i and IFID_mul_i are ignored in this state.
  - The release cycle does not re-trigger the multiply, since RUN is entered only after the multiply has left ID.
- Total multiply stall: exactly MUL_LAT cycles (issue cycle plus MUL_LAT-1 wait cycles), followed by one release cycle.
- Back-to-back multiplies: the second issues in the first RUN cycle after release.
- start_i is ignored outside IDLE; a deasserted start_i does not return the block to IDLE.
- Reset asserted mid-MUL_WAIT: immediate return to IDLE, cnt=0, no mul_valid_o pulse.
- The counter is $clog2(MUL_LAT) bits wide and cannot wrap.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt_o [CNT_W] and flush_cnt_o [CNT_W].
  - stall_cnt_o increments on every cycle with pc_write_o=0 outside IDLE.
  - flush_cnt_o increments on every cycle with IFID_flush_o=1.
  - Both saturate at all-ones and reset asynchronously to 0.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then start: rst_i=1 for 2 cycles, start_i=1 at cycle 3 -> pc_write_o=0 through cycle 3, then 1 from cycle 4; busy_o falls at cycle 4.
- Load-use: IDEX_memread_i=1, IDEX_rt_i=5, IFID_rs_i=5 -> exactly 1 stall cycle (IDEX_bubble_o=1). Repeat with IDEX_rt_i=0 -> no stall.
- Multiply, MUL_LAT=4: IFID_mul_i=1 at cycle 10 -> mul_start_o at 10, stall cycles 10-13, mul_valid_o=1 with free-run at 14, RUN at 15.
- Simultaneous events: lu=1, IFID_mul_i=1, branch_taken_i=1 in the same cycle -> stall only, no mul_start_o, no flush. Next cycle (lu=0) -> mul_start_o=1.
- Branch: branch_taken_i=1 in RUN without lu -> IFID_flush_o=1, pc_write_o=1. With HAZARD_PERF_CNT_EN defined -> flush_cnt_o goes 0->1.
- Reset mid-multiply: rst_i pulsed at cnt=2 -> outputs at reset values immediately, mul_valid_o never asserted, counters 0.
